// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte-lane enables, write-first forwarding and a post-reset clear sweep.
// Optional per-lane even parity with fault injection when DPRAM_PARITY_EN is defined.
module dual_port_ram_be #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int INIT_CLEAR = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_data,
  input  logic [ADDR_W-1:0] a_adrs,
  input  logic              a_we,
  input  logic [DATA_W/8-1:0] a_be,
  output logic [DATA_W-1:0] a_val,
  input  logic [DATA_W-1:0] b_data,
  input  logic [ADDR_W-1:0] b_adrs,
  input  logic              b_we,
  input  logic [DATA_W/8-1:0] b_be,
  output logic [DATA_W-1:0] b_val,
  output logic              ready,
  output logic              collision
`ifdef DPRAM_PARITY_EN
  ,
  input  logic              a_inj,
  output logic              a_perr,
  output logic              b_perr
`endif
);
  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [1:0] S_RESET = 2'd0, S_CLEAR = 2'd1, S_READY = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              live, sweep, sameAdr, wrA, wrB;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] oldA, oldB, newA, newB;
  logic [NB-1:0]     aLane, bLane, wA, wB;

  assign ready = (state == S_READY);
  assign live  = !rst && (state == S_READY);
  // The sweep starts on the first edge after release, so address 0 is cleared on that edge.
  assign sweep = !rst && (state != S_READY) && (INIT_CLEAR != 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
      cnt   <= '0;
    end else if (sweep) begin
      cnt   <= cnt + 1'b1;
      state <= (&cnt) ? S_READY : S_CLEAR;
    end else if (state == S_RESET) begin
      state <= S_READY;
    end
  end

  // Per-lane merge: a port's own enabled lanes win, port A beats port B on shared lanes.
  always_comb begin
    oldA    = mem[a_adrs];
    oldB    = mem[b_adrs];
    sameAdr = (a_adrs == b_adrs);
    newA    = oldA;
    newB    = oldB;
    aLane   = a_be & {NB{a_we}};
    bLane   = b_be & {NB{b_we}};
    wA      = aLane | (bLane & {NB{sameAdr}});
    wB      = bLane | (aLane & {NB{sameAdr}});
    for (int i = 0; i < NB; i++) begin
      if (aLane[i])                 newA[8*i +: 8] = a_data[8*i +: 8];
      else if (sameAdr && bLane[i]) newA[8*i +: 8] = b_data[8*i +: 8];
      if (sameAdr && aLane[i])      newB[8*i +: 8] = a_data[8*i +: 8];
      else if (bLane[i])            newB[8*i +: 8] = b_data[8*i +: 8];
    end
    wrA = live && (|aLane);
    // When both hit one address the merged words are identical; only A's path stores it.
    wrB = live && (|bLane) && !(sameAdr && wrA);
  end

  always_ff @(posedge clk) begin
    if (sweep) mem[cnt] <= CLEAR_VAL;
    if (wrA)   mem[a_adrs] <= newA;
    if (wrB)   mem[b_adrs] <= newB;
  end

  always_ff @(posedge clk) begin
    if (!live) begin
      a_val     <= '0;
      b_val     <= '0;
      collision <= 1'b0;
    end else begin
      a_val     <= newA;
      b_val     <= newB;
      collision <= sameAdr && (|(aLane & bLane));
    end
  end

`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] oldPA, oldPB, newPA, newPB, errA, errB, clrPar;

  // Lanes freshly written in this cycle are forwarded data and always check clean.
  always_comb begin
    oldPA = par[a_adrs];
    oldPB = par[b_adrs];
    newPA = oldPA;
    newPB = oldPB;
    errA  = '0;
    errB  = '0;
    clrPar = '0;
    for (int i = 0; i < NB; i++) begin
      clrPar[i] = ^CLEAR_VAL[8*i +: 8];
      if (wA[i]) newPA[i] = (^newA[8*i +: 8]) ^ (a_inj & aLane[i]);
      if (wB[i]) newPB[i] = ^newB[8*i +: 8];
      errA[i] = !wA[i] && ((^oldA[8*i +: 8]) != oldPA[i]);
      errB[i] = !wB[i] && ((^oldB[8*i +: 8]) != oldPB[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (sweep) par[cnt] <= clrPar;
    if (wrA)   par[a_adrs] <= newPA;
    if (wrB)   par[b_adrs] <= newPB;
  end

  always_ff @(posedge clk) begin
    if (!live) begin
      a_perr <= 1'b0;
      b_perr <= 1'b0;
    end else begin
      a_perr <= |errA;
      b_perr <= |errB;
    end
  end
`endif

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed-vector bench for dual_port_ram_be: clear sweep, byte lanes, collisions, forwarding.
module tb_dual_port_ram_be;
  localparam int DW = 16, AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a_data, b_data, a_val, b_val;
  logic [AW-1:0] a_adrs, b_adrs;
  logic          a_we, b_we, ready, collision;
  logic [1:0]    a_be, b_be;
`ifdef DPRAM_PARITY_EN
  logic          a_inj, a_perr, b_perr;
`endif

  int vecs = 0, errs = 0;
  int n;

  always #5 clk = ~clk;

  dual_port_ram_be #(.DATA_W(DW), .ADDR_W(AW), .INIT_CLEAR(1), .CLEAR_VAL(16'hA5A5)) dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_adrs(a_adrs), .a_we(a_we), .a_be(a_be), .a_val(a_val),
    .b_data(b_data), .b_adrs(b_adrs), .b_we(b_we), .b_be(b_be), .b_val(b_val),
    .ready(ready), .collision(collision)
`ifdef DPRAM_PARITY_EN
    , .a_inj(a_inj), .a_perr(a_perr), .b_perr(b_perr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setA(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [1:0] be);
    a_we = we; a_adrs = ad; a_data = d; a_be = be;
  endtask

  task automatic setB(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [1:0] be);
    b_we = we; b_adrs = ad; b_data = d; b_be = be;
  endtask

  // Counts edges from reset release until ready, bounded at 40.
  task automatic waitReady(output int cycles);
    cycles = 0;
    while (!ready && cycles < 40) begin
      tick();
      cycles++;
      if (cycles == 8) chk("sweep_a_val_zero", a_val, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    setA(0, 0, 0, 0);
    setB(0, 0, 0, 0);
`ifdef DPRAM_PARITY_EN
    a_inj = 1'b0;
`endif
    tick(); tick();
    chk("rst_ready", ready, 0);
    chk("rst_a_val", a_val, 0);
    chk("rst_b_val", b_val, 0);
    chk("rst_collision", collision, 0);

    rst = 1'b0;
    waitReady(n);
    chk("sweep_len", n, 16);

    // reset in the middle of the sweep, user write attempted during the restart
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (5) tick();
    chk("midsweep_not_ready", ready, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    setA(1, 2, 16'h1111, 2'b11);
    waitReady(n);
    chk("resweep_len", n, 16);
    setA(0, 2, 0, 0);
    tick();
    chk("sweep_ignores_we", a_val, 16'hA5A5);

    setA(0, 7, 0, 0);
    tick();
    chk("read7_latency1", a_val, 16'hA5A5);

    // byte lanes
    setA(1, 3, 16'h1234, 2'b11); tick();
    chk("be11_writethru", a_val, 16'h1234);
    setA(1, 3, 16'hFFEE, 2'b01); tick();
    chk("be01_writethru", a_val, 16'h12EE);
    setA(0, 3, 0, 0); setB(0, 3, 0, 0); tick();
    chk("be01_readback_a", a_val, 16'h12EE);
    chk("be01_readback_b", b_val, 16'h12EE);
    setA(1, 3, 16'h0000, 2'b00); tick();
    chk("be00_is_read", a_val, 16'h12EE);

    // full-overlap collision: A wins
    setA(1, 5, 16'hAAAA, 2'b11); setB(1, 5, 16'hBBBB, 2'b11); tick();
    chk("coll_a_val", a_val, 16'hAAAA);
    chk("coll_b_val", b_val, 16'hAAAA);
    chk("coll_pulse", collision, 1);
    setA(0, 5, 0, 0); setB(0, 5, 0, 0); tick();
    chk("coll_pulse_ends", collision, 0);
    chk("coll_stored", a_val, 16'hAAAA);

    // disjoint lanes: merge, no pulse
    setA(1, 5, 16'hAAAA, 2'b01); setB(1, 5, 16'hBBBB, 2'b10); tick();
    chk("merge_a_val", a_val, 16'hBBAA);
    chk("merge_b_val", b_val, 16'hBBAA);
    chk("merge_no_pulse", collision, 0);
    setA(0, 5, 0, 0); setB(0, 0, 0, 0); tick();
    chk("merge_stored", a_val, 16'hBBAA);

    // back-to-back collisions on addr 6
    setA(1, 6, 16'h1111, 2'b11); setB(1, 6, 16'h2222, 2'b01); tick();
    chk("b2b_pulse1", collision, 1);
    setA(1, 6, 16'h3333, 2'b10); setB(1, 6, 16'h4444, 2'b11); tick();
    chk("b2b_pulse2", collision, 1);
    chk("b2b_merge", b_val, 16'h3344);
    setA(0, 6, 0, 0); setB(0, 6, 0, 0); tick();
    chk("b2b_end", collision, 0);

    // cross-port forwarding both directions
    setA(1, 9, 16'hC0DE, 2'b11); setB(0, 9, 0, 0); tick();
    chk("fwd_a_to_b", b_val, 16'hC0DE);
    chk("fwd_a_self", a_val, 16'hC0DE);
    setA(0, 10, 0, 0); setB(1, 10, 16'h1357, 2'b10); tick();
    chk("fwd_b_to_a", a_val, 16'h13A5);

    // independent addresses
    setA(1, 11, 16'h0F0F, 2'b11); setB(1, 12, 16'hF0F0, 2'b11); tick();
    chk("indep_no_pulse", collision, 0);
    chk("indep_a_val", a_val, 16'h0F0F);
    setA(0, 12, 0, 0); setB(0, 11, 0, 0); tick();
    chk("indep_a_read12", a_val, 16'hF0F0);
    chk("indep_b_read11", b_val, 16'h0F0F);

`ifdef DPRAM_PARITY_EN
    chk("par_clean_read", a_perr, 0);
    setA(1, 13, 16'h5555, 2'b11); a_inj = 1'b1; tick();
    a_inj = 1'b0;
    chk("par_fwd_clean", a_perr, 0);
    setA(0, 13, 0, 0); setB(0, 12, 0, 0); tick();
    chk("par_inj_data", a_val, 16'h5555);
    chk("par_inj_err", a_perr, 1);
    chk("par_b_clean", b_perr, 0);
`endif

    // reset after traffic
    setA(0, 0, 0, 0); setB(0, 0, 0, 0);
    rst = 1'b1; tick();
    chk("rst2_ready", ready, 0);
    chk("rst2_a_val", a_val, 0);
    chk("rst2_b_val", b_val, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
